// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
package seq_det_pkg;

  // Legal range for the pattern length parameter.
  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 32;

  // Detector state; it mirrors the history fill level.
  //   EMPTY: no bits collected since the last clear
  //   FILL : partially collected
  //   ARMED: a full window of bits is available for comparison
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } state_e;

  // Map the fill level flags onto the state encoding.
  function automatic state_e fill_state(input logic is_empty, input logic is_full);
    if (is_empty) begin
      return EMPTY;
    end else if (is_full) begin
      return ARMED;
    end else begin
      return FILL;
    end
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: counts inc pulses, holds at all ones, clears on rst or clr.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc, stick at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Parameterised serial sequence detector with configurable pattern and
// overlap mode. Define SEQ_DET_COUNT_EN to add the saturating match_count
// output and its counter; without it the port and logic are absent and dout
// behaves identically.
//
// Handshake: din is accepted on a rising edge only when din_valid is high and
// cfg_load is low; cfg_load wins over din_valid, and rst wins over both.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  output logic               dout
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_count
`endif
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

  // Reject out-of-range parameters at elaboration time.
  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
    $error("seq_det_param: PAT_LEN out of range");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("seq_det_param: CNT_W out of range");
  end

  logic [PAT_LEN-1:0] hist_q;
  logic [PAT_LEN-1:0] pat_q;
  logic [FILL_W-1:0]  fill_q;
  logic               ovl_q;
  logic               dout_q;
  state_e             state_q;

  logic               accept;
  logic [PAT_LEN-1:0] hist_d;
  logic [FILL_W-1:0]  fill_d;
  logic               match;

  // Post-shift history and fill for the bit presented this cycle.
  always_comb begin
    accept = din_valid & ~cfg_load;
    hist_d = {hist_q[PAT_LEN-2:0], din};
    fill_d = (fill_q == FILL_FULL) ? fill_q : (fill_q + FILL_ONE);
    match  = accept && (fill_d == FILL_FULL) && (hist_d == pat_q);
  end

  // Detector FSM: history, fill level, state, config and registered pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= EMPTY;
      pat_q   <= '1;
      ovl_q   <= 1'b1;
      dout_q  <= 1'b0;
    end else if (cfg_load) begin
      // A same-cycle din bit is dropped on purpose.
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= EMPTY;
      pat_q   <= cfg_pattern;
      ovl_q   <= cfg_overlap;
      dout_q  <= 1'b0;
    end else if (din_valid) begin
      hist_q <= hist_d;
      dout_q <= match;
      if (match && !ovl_q) begin
        // Non-overlapping: the next match needs a full set of fresh bits.
        fill_q  <= '0;
        state_q <= EMPTY;
      end else begin
        fill_q  <= fill_d;
        state_q <= fill_state(1'b0, fill_d == FILL_FULL);
      end
    end else begin
      dout_q <= 1'b0;
    end
  end

  assign dout = dout_q;

`ifdef SEQ_DET_COUNT_EN
  // Match total; cleared by reset or a configuration load.
  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load),
    .inc (match),
    .cnt (match_count)
  );
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: a table of directed vectors on a default instance,
// plus hand-written sequences on a CNT_W=2 instance for saturation and reset.
module tb_seq_det_param;
  import seq_det_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance signals
  logic       rst, din_valid, din, cfg_load, cfg_overlap;
  logic [2:0] cfg_pattern;
  logic       dout;
  // CNT_W=2 instance signals
  logic       c2_rst, c2_valid, c2_din, c2_load, c2_overlap;
  logic [2:0] c2_pattern;
  logic       c2_dout;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] match_count;
  logic [1:0] c2_count;
`endif

  seq_det_param #(.PAT_LEN(3), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .dout        (dout)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (match_count)
`endif
  );

  seq_det_param #(.PAT_LEN(3), .CNT_W(2)) dut_c2 (
    .clk         (clk),
    .rst         (c2_rst),
    .din_valid   (c2_valid),
    .din         (c2_din),
    .cfg_load    (c2_load),
    .cfg_pattern (c2_pattern),
    .cfg_overlap (c2_overlap),
    .dout        (c2_dout)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_count (c2_count)
`endif
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       vld;
    logic       din;
    logic       load;
    logic [2:0] pat;
    logic       ovl;
    logic       exp_dout;
    int         exp_cnt;
    logic       chk_st;
    state_e     exp_st;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input logic r, input logic v, input logic d, input logic l,
                     input logic [2:0] p, input logic o, input logic ed,
                     input int ec, input logic ck, input state_e es);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.load = l; t.pat = p; t.ovl = o;
    t.exp_dout = ed; t.exp_cnt = ec; t.chk_st = ck; t.exp_st = es;
    vecs.push_back(t);
  endtask

  // data bit, valid, no config
  task automatic bit_in(input logic d, input logic ed, input int ec);
    add(1'b0, 1'b1, d, 1'b0, 3'b000, 1'b0, ed, ec, 1'b0, EMPTY);
  endtask

  task automatic bit_in_st(input logic d, input logic ed, input int ec, input state_e es);
    add(1'b0, 1'b1, d, 1'b0, 3'b000, 1'b0, ed, ec, 1'b1, es);
  endtask

  task automatic gap(input int ec);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, ec, 1'b0, EMPTY);
  endtask

  task automatic load(input logic [2:0] p, input logic o);
    add(1'b0, 1'b0, 1'b0, 1'b1, p, o, 1'b0, 0, 1'b1, EMPTY);
  endtask

  // ---------------- driver / checker ----------------
  task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.rst; din_valid = t.vld; din = t.din;
    cfg_load = t.load; cfg_pattern = t.pat; cfg_overlap = t.ovl;
    @(posedge clk);
    #1;
    check_bit("dout", idx, dout, t.exp_dout);
`ifdef SEQ_DET_COUNT_EN
    n_vec++;
    if (match_count !== 8'(t.exp_cnt)) begin
      n_fail++;
      $display("FAIL match_count #%0d: got %0d expected %0d", idx, match_count, t.exp_cnt);
    end
`endif
    if (t.chk_st) begin
      n_vec++;
      if (dut.state_q !== t.exp_st) begin
        n_fail++;
        $display("FAIL state #%0d: got %0d expected %0d", idx, dut.state_q, t.exp_st);
      end
    end
  endtask

  task automatic c2_step(input logic r, input logic v, input logic d,
                         input logic ed, input int ec, input string name);
    @(negedge clk);
    c2_rst = r; c2_valid = v; c2_din = d;
    @(posedge clk);
    #1;
    check_bit(name, n_vec, c2_dout, ed);
`ifdef SEQ_DET_COUNT_EN
    n_vec++;
    if (c2_count !== 2'(ec)) begin
      n_fail++;
      $display("FAIL c2_count %s: got %0d expected %0d", name, c2_count, ec);
    end
`else
    if (ec < 0) $display("negative expected count %0d", ec);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 3'b000; cfg_overlap = 1'b0;
    c2_rst = 1'b1; c2_valid = 1'b0; c2_din = 1'b0; c2_load = 1'b0;
    c2_pattern = 3'b000; c2_overlap = 1'b0;

    // reset state
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0, 1'b1, EMPTY);
    // default pattern 111, overlap: pulses after bits 3, 4, 8
    bit_in(1, 0, 0);
    bit_in_st(1, 0, 0, FILL);
    bit_in_st(1, 1, 1, ARMED);
    bit_in(1, 1, 2); bit_in(0, 0, 2); bit_in(1, 0, 2);
    bit_in(1, 0, 2); bit_in(1, 1, 3); bit_in(0, 0, 3);
    // pattern 111, non-overlap: pulses after bits 3 and 8
    load(3'b111, 1'b0);
    bit_in(1, 0, 0); bit_in(1, 0, 0);
    bit_in_st(1, 1, 1, EMPTY);
    bit_in(1, 0, 1); bit_in(0, 0, 1); bit_in(1, 0, 1);
    bit_in(1, 0, 1); bit_in(1, 1, 2); bit_in(0, 0, 2);
    // pattern 101 overlap: pulses after bits 3 and 5
    load(3'b101, 1'b1);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 1, 1);
    bit_in(0, 0, 1); bit_in_st(1, 1, 2, ARMED);
    // pattern 101 non-overlap: pulse after bit 3 only
    load(3'b101, 1'b0);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 1, 1);
    bit_in(0, 0, 1); bit_in(1, 0, 1);
    // gaps of two invalid cycles between 1,1,1
    load(3'b111, 1'b1);
    bit_in(1, 0, 0); gap(0); gap(0);
    bit_in(1, 0, 0); gap(0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 0, 1'b1, FILL);
    bit_in(1, 1, 1);
    // cfg_load beats a same-cycle valid bit
    load(3'b111, 1'b1);
    bit_in(1, 0, 0); bit_in(1, 0, 0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 0, 1'b1, EMPTY);
    bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1);
    // rst beats cfg_load and din: defaults 111/overlap restored
    add(1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 0, 1'b1, EMPTY);
    bit_in(1, 0, 0); bit_in(1, 0, 0); bit_in(1, 1, 1); bit_in(1, 1, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 2, 1'b1, ARMED);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // CNT_W=2: five overlapping matches saturate at 3
    c2_step(1, 0, 0, 0, 0, "c2_rst");
    c2_step(0, 1, 1, 0, 0, "c2_b1");
    c2_step(0, 1, 1, 0, 0, "c2_b2");
    c2_step(0, 1, 1, 1, 1, "c2_b3");
    c2_step(0, 1, 1, 1, 2, "c2_b4");
    c2_step(0, 1, 1, 1, 3, "c2_b5");
    c2_step(0, 1, 1, 1, 3, "c2_b6");
    c2_step(0, 1, 1, 1, 3, "c2_b7");
    // rst mid-stream after 1,1: the next 1 must not pulse
    c2_step(1, 0, 0, 0, 0, "c2_rst2");
    c2_step(0, 1, 1, 0, 0, "c2_r1");
    c2_step(0, 1, 1, 0, 0, "c2_r2");
    c2_step(1, 1, 1, 0, 0, "c2_rst_mid");
    c2_step(0, 1, 1, 0, 0, "c2_after_rst");
    c2_step(0, 1, 1, 0, 0, "c2_after_rst2");
    c2_step(0, 1, 1, 1, 1, "c2_after_rst3");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
